// File: rtl/adc_avg_sequencer.sv
// -----------------------------------------------------------------------------
// adc_avg_sequencer
//
// Paces a SAR ADC through its start/ready handshake at a programmable sample
// rate, accumulates 2^AVG_LOG2 consecutive conversion results and presents
// their truncated average on a valid/ready output port.
//
// Ports:
//   clk_i         system clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   en_i          enable sampling; low discards any partial average
//   period_i      sample period in clk cycles (0 behaves as 1)
//   adc_start_o   start request to the ADC (high in START)
//   adc_rdy_i     ADC conversion done
//   adc_result_i  ADC result, valid in the first cycle adc_rdy_i is low again
//   data_o        averaged result
//   valid_o       data_o holds an unconsumed word
//   ready_i       consumer accepts data_o
//   overrun_o     sticky: an unconsumed word was overwritten
//   timeout_o     sticky: ADC ready not seen within TIMEOUT cycles
//   clr_flags_i   clears overrun_o and timeout_o (a simultaneous set wins)
//   busy_o        conversion FSM is not idle
// -----------------------------------------------------------------------------
module adc_avg_sequencer #(
   parameter int RESOLUTION = 8,
   parameter int AVG_LOG2   = 2,
   parameter int DIV_WIDTH  = 16,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [DIV_WIDTH-1:0]  period_i,
   output logic                  adc_start_o,
   input  logic                  adc_rdy_i,
   input  logic [RESOLUTION-1:0] adc_result_i,
   output logic [RESOLUTION-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  overrun_o,
   output logic                  timeout_o,
   input  logic                  clr_flags_i,
   output logic                  busy_o
);

   // Accumulator holds at most 2^AVG_LOG2 full-scale samples, so it cannot wrap.
   localparam int ACC_W  = RESOLUTION + AVG_LOG2;
   localparam int CNT_W  = AVG_LOG2 + 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_RELEASE
   } state_e;

   state_e                state_q,   state_d;
   logic [DIV_WIDTH-1:0]  timer_q,   timer_d;
   logic                  pending_q, pending_d;
   logic [WAIT_W-1:0]     wait_q,    wait_d;
   logic [ACC_W-1:0]      acc_q,     acc_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic [RESOLUTION-1:0] data_q,    data_d;
   logic                  valid_q,   valid_d;
   logic                  overrun_q, overrun_d;
   logic                  timeout_q, timeout_d;

   logic                  tick;
   logic                  load_word;
   logic                  timeout_set;
   logic [ACC_W-1:0]      acc_sum;

   // -------------------------------------------------------------------------
   // Sample-rate timer: one tick every max(period_i,1) cycles while enabled,
   // with the first tick on the first enabled cycle.
   // -------------------------------------------------------------------------
   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      tick    = 1'b0;
      timer_d = '0;
      if (en_i) begin
         if (timer_q == '0) begin
            tick    = 1'b1;
            timer_d = (period_i == '0) ? '0 : period_i - DIV_WIDTH'(1);
         end else begin
            timer_d = timer_q - DIV_WIDTH'(1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Conversion FSM, accumulator and output port next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      wait_d      = '0;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      load_word   = 1'b0;
      timeout_set = 1'b0;
      acc_sum     = acc_q + ACC_W'(adc_result_i);

      unique case (state_q)
         S_IDLE: begin
            if (!en_i) begin
               acc_d = '0;
               cnt_d = '0;
            end else if (pending_q) begin
               pending_d = 1'b0;
               state_d   = S_START;
            end
         end

         S_START: begin
            if (adc_rdy_i) begin
               state_d = S_RELEASE;
            end else if (wait_q == WAIT_LAST) begin
               // Abandon this sample only; the partial average is kept.
               timeout_set = 1'b1;
               state_d     = S_IDLE;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         S_RELEASE: begin
            // The ADC updates its result as it leaves done, so the sample is
            // taken in the first cycle ready is low again.
            if (!adc_rdy_i) begin
               state_d = S_IDLE;
               if (!en_i) begin
                  acc_d = '0;
                  cnt_d = '0;
               end else if (cnt_q == CNT_LAST) begin
                  data_d    = RESOLUTION'(acc_sum >> AVG_LOG2);
                  load_word = 1'b1;
                  acc_d     = '0;
                  cnt_d     = '0;
               end else begin
                  acc_d = acc_sum;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Ticks collapse into a single pending start; disabling drops it.
      if (!en_i) begin
         pending_d = 1'b0;
      end else if (tick) begin
         pending_d = 1'b1;
      end

      // A new word takes priority over a transfer in the same cycle.
      valid_d = valid_q;
      if (load_word) begin
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      overrun_d = (load_word && valid_q && !ready_i) || (overrun_q && !clr_flags_i);
      timeout_d = timeout_set || (timeout_q && !clr_flags_i);
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   // NOTE: all state here is flops, not an array, so everything is reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         pending_q <= 1'b0;
         wait_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
         wait_q    <= wait_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
      end
   end

   assign adc_start_o = (state_q == S_START);
   assign busy_o      = (state_q != S_IDLE);
   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign overrun_o   = overrun_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_avg_sequencer
//
// Directed bench for adc_avg_sequencer with a behavioural SAR ADC model
// (ready 10 cycles after start, held until start drops, result updated as
// ready falls) and a scoreboard of expected averaged words.
// -----------------------------------------------------------------------------
module tb_adc_avg_sequencer;

   localparam int ADC_LAT = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] period;
   logic        adc_start_o;
   logic        adc_rdy = 1'b0;
   logic [7:0]  adc_result = 8'h00;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic        overrun_o;
   logic        timeout_o;
   logic        clr_flags;
   logic        busy_o;

   always #5 clk = ~clk;

   adc_avg_sequencer #(
      .RESOLUTION (8),
      .AVG_LOG2   (2),
      .DIV_WIDTH  (16),
      .TIMEOUT    (64)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .period_i     (period),
      .adc_start_o  (adc_start_o),
      .adc_rdy_i    (adc_rdy),
      .adc_result_i (adc_result),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .overrun_o    (overrun_o),
      .timeout_o    (timeout_o),
      .clr_flags_i  (clr_flags),
      .busy_o       (busy_o)
   );

   int         checks   = 0;
   int         failures = 0;

   logic [7:0] adc_vals[$];   // results the ADC model hands out, in order
   logic [7:0] exp_q[$];      // scoreboard of expected output words
   logic       adc_dead = 1'b0;
   int         adc_wait = 0;
   int         adc_pops = 0;

   int         cyc = 0;
   int         rise_cyc[$];
   int         valid_cycles = 0;
   logic       start_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ADC model
   always @(posedge clk) begin
      if (adc_start_o && !adc_rdy && !adc_dead) begin
         if (adc_wait == ADC_LAT - 1) adc_rdy <= 1'b1;
         else                         adc_wait <= adc_wait + 1;
      end
      if (!adc_start_o) begin
         adc_wait <= 0;
         if (adc_rdy) begin
            adc_rdy  <= 1'b0;
            adc_pops <= adc_pops + 1;
            if (adc_vals.size() != 0) adc_result <= adc_vals.pop_front();
            else                      adc_result <= 8'h40;
         end
      end
   end

   // Monitor and scoreboard, sampled away from the active edge
   always @(negedge clk) begin
      cyc        <= cyc + 1;
      start_prev <= adc_start_o;
      if (adc_start_o && !start_prev) rise_cyc.push_back(cyc);
      if (valid_o) valid_cycles <= valid_cycles + 1;
      if (valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               failures++;
               $error("FAIL sb_unexpected_word observed=0x%0h expected=none", data_o);
            end
         end else begin
            chk("sb_data", 32'(data_o), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pops(input int target, input string tag);
      int n = 0;
      while (adc_pops < target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(adc_pops >= target), 32'd1);
   endtask

   task automatic wait_busy(input logic val, input string tag);
      int n = 0;
      while (busy_o !== val && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy_o), 32'(val));
   endtask

   task automatic wait_start(input logic val, input string tag);
      int n = 0;
      while (adc_start_o !== val && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(adc_start_o), 32'(val));
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_state(input string pfx);
      chk({pfx, "_data"},    32'(data_o),      32'd0);
      chk({pfx, "_valid"},   32'(valid_o),     32'd0);
      chk({pfx, "_overrun"}, 32'(overrun_o),   32'd0);
      chk({pfx, "_timeout"}, 32'(timeout_o),   32'd0);
      chk({pfx, "_start"},   32'(adc_start_o), 32'd0);
      chk({pfx, "_busy"},    32'(busy_o),      32'd0);
   endtask

   initial begin
      int r0;
      int v0;
      int p0;
      int hi;
      int gap;

      rst       = 1'b1;
      en        = 1'b0;
      period    = 16'd20;
      ready_i   = 1'b1;
      clr_flags = 1'b0;
      tick(3);
      check_reset_state("reset");
      rst = 1'b0;
      tick(2);

      // Four conversions of 0x40 at period 20
      r0 = rise_cyc.size();
      v0 = valid_cycles;
      p0 = adc_pops;
      repeat (4) adc_vals.push_back(8'h40);
      exp_q.push_back(8'h40);
      en = 1'b1;
      wait_pops(p0 + 4, "a_pops");
      drain("a_drain");
      tick(2);
      en = 1'b0;
      chk("a_spacing_01", 32'(rise_cyc[r0 + 1] - rise_cyc[r0]), 32'd20);
      chk("a_spacing_23", 32'(rise_cyc[r0 + 3] - rise_cyc[r0 + 2]), 32'd20);
      chk("a_valid_cycles", 32'(valid_cycles - v0), 32'd1);
      tick(3);

      // Truncating average: (1+2+3+5)>>2 = 2
      p0 = adc_pops;
      adc_vals.push_back(8'h01);
      adc_vals.push_back(8'h02);
      adc_vals.push_back(8'h03);
      adc_vals.push_back(8'h05);
      exp_q.push_back(8'h02);
      en = 1'b1;
      wait_pops(p0 + 4, "b_pops");
      drain("b_drain");
      en = 1'b0;
      tick(3);

      // Timeout on the third conversion keeps the partial average
      period = 16'd100;
      p0     = adc_pops;
      adc_vals.push_back(8'h10);
      adc_vals.push_back(8'h20);
      adc_vals.push_back(8'h30);
      adc_vals.push_back(8'h40);
      exp_q.push_back(8'h28);
      en = 1'b1;
      wait_pops(p0 + 2, "to_pre_pops");
      adc_dead = 1'b1;
      wait_start(1'b1, "to_start_seen");
      hi = 0;
      while (adc_start_o === 1'b1 && hi < 200) begin
         hi++;
         @(negedge clk);
      end
      chk("to_start_len", 32'(hi), 32'd64);
      chk("to_flag", 32'(timeout_o), 32'd1);
      chk("to_idle", 32'(busy_o), 32'd0);
      adc_dead = 1'b0;
      wait_pops(p0 + 4, "to_post_pops");
      drain("to_drain");
      en = 1'b0;
      chk("to_sticky", 32'(timeout_o), 32'd1);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      chk("to_clear", 32'(timeout_o), 32'd0);
      tick(3);

      // period 0: back-to-back conversions, one idle cycle between them
      period = 16'd0;
      p0     = adc_pops;
      adc_vals.push_back(8'h10);
      adc_vals.push_back(8'h20);
      adc_vals.push_back(8'h30);
      adc_vals.push_back(8'h40);
      exp_q.push_back(8'h28);
      en = 1'b1;
      wait_busy(1'b1, "p0_first_busy");
      repeat (2) begin
         wait_busy(1'b0, "p0_idle_seen");
         gap = 0;
         while (busy_o === 1'b0 && gap < 50) begin
            gap++;
            @(negedge clk);
         end
         chk("p0_idle_gap", 32'(gap), 32'd1);
      end
      wait_pops(p0 + 4, "p0_pops");
      drain("p0_drain");
      en = 1'b0;
      wait_busy(1'b0, "p0_stop");
      tick(3);

      // en dropped during START: handshake completes, sample discarded
      period = 16'd20;
      p0     = adc_pops;
      v0     = valid_cycles;
      adc_vals.push_back(8'h77);
      en = 1'b1;
      wait_start(1'b1, "ed_start_seen");
      tick(2);
      en = 1'b0;
      @(negedge clk);
      chk("ed_busy", 32'(busy_o), 32'd1);
      chk("ed_start_held", 32'(adc_start_o), 32'd1);
      wait_pops(p0 + 1, "ed_handshake");
      wait_busy(1'b0, "ed_idle");
      tick(3);
      chk("ed_no_word", 32'(valid_cycles - v0), 32'd0);
      chk("ed_valid", 32'(valid_o), 32'd0);
      p0 = adc_pops;
      repeat (4) adc_vals.push_back(8'h08);
      exp_q.push_back(8'h08);
      en = 1'b1;
      wait_pops(p0 + 4, "ed_after_pops");
      drain("ed_after_drain");
      en = 1'b0;
      tick(3);

      // Consumer stalled: second word overwrites the first
      ready_i = 1'b0;
      p0      = adc_pops;
      repeat (4) adc_vals.push_back(8'h10);
      adc_vals.push_back(8'h20);
      adc_vals.push_back(8'h20);
      adc_vals.push_back(8'h24);
      adc_vals.push_back(8'h20);
      en = 1'b1;
      wait_pops(p0 + 4, "ov_pops1");
      wait_busy(1'b0, "ov_idle1");
      chk("ov_first_valid", 32'(valid_o), 32'd1);
      chk("ov_first_data", 32'(data_o), 32'h10);
      chk("ov_first_no_overrun", 32'(overrun_o), 32'd0);
      wait_pops(p0 + 8, "ov_pops2");
      wait_busy(1'b0, "ov_idle2");
      chk("ov_valid", 32'(valid_o), 32'd1);
      chk("ov_data", 32'(data_o), 32'h21);
      chk("ov_flag", 32'(overrun_o), 32'd1);
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      chk("ov_clear", 32'(overrun_o), 32'd0);
      chk("ov_valid_kept", 32'(valid_o), 32'd1);

      // Reset while in RELEASE
      wait_start(1'b1, "rr_start_seen");
      wait_start(1'b0, "rr_release_seen");
      chk("rr_in_release", 32'(busy_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("rr");
      rst     = 1'b0;
      en      = 1'b0;
      ready_i = 1'b1;
      tick(5);
      chk("sb_empty_end", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
